// File: rtl/nucleo_bichinho.sv
// Virtual-pet core: prescaled decay tick, menu/action/animation FSM, death and restart.
// Define NUCLEO_BICHINHO_IDADE_EN to add the 16-bit age counter output idade.
module nucleo_bichinho #(
    parameter int N_ATTR     = 3,
    parameter int ATTR_W     = 8,
    parameter int TICK_DIV   = 12000000,
    parameter int DEC_STEP   = 1,
    parameter int ACT_STEP   = 16,
    parameter int MENU_TO    = 5,
    parameter int ANIM_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     b_sel,
    input  logic                     b_ok,
    output logic [3:0]               estado,
    output logic [2:0]               sel,
    output logic [N_ATTR*ATTR_W-1:0] attr,
    output logic                     tick,
    output logic                     morreu
`ifdef NUCLEO_BICHINHO_IDADE_EN
    ,
    output logic [15:0]              idade
`endif
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (MENU_TO > 1) ? $clog2(MENU_TO + 1) : 1;
    localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS + 1) : 1;
    localparam int SW = ATTR_W + 2;

    localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0]        MENU_LAST  = MW'(MENU_TO - 1);
    localparam logic [AW-1:0]        ANIM_LAST  = AW'(ANIM_TICKS - 1);
    localparam logic [2:0]           SEL_LAST   = 3'(N_ATTR - 1);
    localparam logic [ATTR_W-1:0]    ATTR_MAX   = '1;
    localparam logic signed [SW-1:0] DEC_S      = SW'(DEC_STEP);
    localparam logic signed [SW-1:0] ACT_S      = SW'(ACT_STEP);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        MENU  = 4'd1,
        ACAO  = 4'd2,
        ANIM  = 4'd3,
        MORTO = 4'd4
    } state_t;

    state_t                 state_q, state_n;
    logic [2:0]             sel_q, sel_n;
    logic [ATTR_W-1:0]      attr_q [N_ATTR];
    logic [ATTR_W-1:0]      attr_n [N_ATTR];
    logic [PW-1:0]          presc_q, presc_n;
    logic                   tick_q, tick_n;
    logic                   morreu_q, morreu_n;
    logic [MW-1:0]          menu_q, menu_n;
    logic [AW-1:0]          anim_q, anim_n;
    logic                   wrap, any_zero, dying, restart, act;
    logic signed [SW-1:0]   net;

    // Net value is never below -(2^ATTR_W) nor above 2^(ATTR_W+1)-1, so bit ATTR_W flags overflow.
    function automatic logic [ATTR_W-1:0] sat_attr(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v[ATTR_W])
            return ATTR_MAX;
        else
            return v[ATTR_W-1:0];
    endfunction

    always_comb begin
        wrap     = (presc_q == PRESC_LAST);
        any_zero = 1'b0;
        for (int i = 0; i < N_ATTR; i++) begin
            if (attr_q[i] == '0)
                any_zero = 1'b1;
        end
        // tick_q marks the cycle right after a decay update has landed
        dying    = tick_q && any_zero && (state_q != MORTO);
        restart  = (state_q == MORTO) && b_sel && b_ok;
    end

    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        menu_n   = menu_q;
        anim_n   = anim_q;
        act      = 1'b0;
        morreu_n = morreu_q;
        if (dying) begin
            state_n  = MORTO;
            morreu_n = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (b_sel) begin
                        state_n = MENU;
                        sel_n   = '0;
                        menu_n  = '0;
                    end
                end
                MENU: begin
                    if (b_ok) begin
                        state_n = ACAO;
                        menu_n  = '0;
                    end else if (b_sel) begin
                        sel_n  = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
                        menu_n = '0;
                    end else if (wrap) begin
                        if (menu_q == MENU_LAST) begin
                            state_n = IDLE;
                            menu_n  = '0;
                        end else begin
                            menu_n = menu_q + 1'b1;
                        end
                    end
                end
                ACAO: begin
                    act     = 1'b1;
                    state_n = ANIM;
                    anim_n  = '0;
                end
                ANIM: begin
                    if (wrap) begin
                        if (anim_q == ANIM_LAST) begin
                            state_n = IDLE;
                            anim_n  = '0;
                        end else begin
                            anim_n = anim_q + 1'b1;
                        end
                    end
                end
                MORTO: begin
                    if (restart) begin
                        state_n  = IDLE;
                        sel_n    = '0;
                        morreu_n = 1'b0;
                        menu_n   = '0;
                        anim_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        net = '0;
        for (int i = 0; i < N_ATTR; i++) begin
            attr_n[i] = attr_q[i];
            if (restart) begin
                attr_n[i] = ATTR_MAX;
            end else if (state_q != MORTO) begin
                net = $signed({2'b00, attr_q[i]});
                if (wrap)
                    net = net - DEC_S;
                if (act && (sel_q == 3'(i)))
                    net = net + ACT_S;
                attr_n[i] = sat_attr(net);
            end
        end
        presc_n = (restart || wrap) ? '0 : presc_q + 1'b1;
        tick_n  = wrap && !restart;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            morreu_q <= 1'b0;
            menu_q   <= '0;
            anim_q   <= '0;
            for (int i = 0; i < N_ATTR; i++)
                attr_q[i] <= ATTR_MAX;
        end else begin
            sel_q    <= sel_n;
            presc_q  <= presc_n;
            tick_q   <= tick_n;
            morreu_q <= morreu_n;
            menu_q   <= menu_n;
            anim_q   <= anim_n;
            for (int i = 0; i < N_ATTR; i++)
                attr_q[i] <= attr_n[i];
        end
    end

`ifdef NUCLEO_BICHINHO_IDADE_EN
    logic [15:0] idade_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idade_q <= '0;
        else if (restart)
            idade_q <= '0;
        else if (wrap && (state_q != MORTO) && (idade_q != 16'hFFFF))
            idade_q <= idade_q + 16'd1;
    end

    assign idade = idade_q;
`endif

    assign estado = state_q;
    assign sel    = sel_q;
    assign tick   = tick_q;
    assign morreu = morreu_q;

    for (genvar g = 0; g < N_ATTR; g++) begin : g_pack
        assign attr[g*ATTR_W +: ATTR_W] = attr_q[g];
    end

endmodule

// File: tb/tb_nucleo_bichinho.sv
// Directed scoreboard bench for nucleo_bichinho with a fast tick (TICK_DIV=4).
module tb_nucleo_bichinho;

    logic        clk = 1'b0;
    logic        rst;
    logic        b_sel;
    logic        b_ok;
    logic [3:0]  estado;
    logic [2:0]  sel;
    logic [23:0] attr;
    logic        tick;
    logic        morreu;
`ifdef NUCLEO_BICHINHO_IDADE_EN
    logic [15:0] idade;
`endif

    int tests = 0;
    int fails = 0;
    int ea [3];

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb [$];

    nucleo_bichinho #(
        .N_ATTR(3), .ATTR_W(8), .TICK_DIV(4), .DEC_STEP(1),
        .ACT_STEP(16), .MENU_TO(3), .ANIM_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .b_sel(b_sel), .b_ok(b_ok),
        .estado(estado), .sel(sel), .attr(attr), .tick(tick), .morreu(morreu)
`ifdef NUCLEO_BICHINHO_IDADE_EN
        , .idade(idade)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic exp_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sat8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] pk();
        return {8'(ea[2]), 8'(ea[1]), 8'(ea[0])};
    endfunction

    task automatic decay();
        for (int i = 0; i < 3; i++) ea[i] = sat8(ea[i] - 1);
    endtask

    task automatic set_full();
        for (int i = 0; i < 3; i++) ea[i] = 255;
    endtask

    // Advance to the next visible tick pulse (bounded) and check the decayed attributes.
    task automatic tick_step(input int st);
        int n;
        decay();
        exp_v("tick_pulse", 1);
        exp_v("tick_attr", pk());
        exp_v("tick_estado", st);
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick !== 1'b1 && n < 8);
        check(tick);
        check(attr);
        check(estado);
    endtask

    initial begin
        rst   = 1'b1;
        b_sel = 1'b0;
        b_ok  = 1'b0;
        set_full();

        // reset state
        exp_v("rst_attr", 24'hFFFFFF);
        exp_v("rst_estado", 0);
        exp_v("rst_sel", 0);
        exp_v("rst_morreu", 0);
        exp_v("rst_tick", 0);
        step(2);
        check(attr); check(estado); check(sel); check(morreu); check(tick);
        rst = 1'b0;

        // first tick exactly four cycles after release
        exp_v("pre_tick", 0);
        exp_v("pre_tick_attr", 24'hFFFFFF);
        step(3);
        check(tick); check(attr);
        decay();
        exp_v("first_tick", 1);
        exp_v("first_tick_attr", 24'hFEFEFE);
        step(1);
        check(tick); check(attr);

        // menu: enter, advance with wrap, timeout
        b_sel = 1'b1;
        exp_v("menu_enter_estado", 1);
        exp_v("menu_enter_sel", 0);
        step(1);
        check(estado); check(sel);
        exp_v("menu_sel1", 1);
        step(1);
        check(sel);
        exp_v("menu_sel2", 2);
        step(1);
        check(sel);
        decay();
        exp_v("menu_sel_wrap", 0);
        exp_v("menu_wrap_attr", pk());
        step(1);
        check(sel); check(attr);
        b_sel = 1'b0;
        tick_step(1);
        tick_step(1);
        tick_step(0);
        exp_v("menu_to_sel", 0);
        check(sel);

        // b_ok in IDLE ignored
        b_ok = 1'b1;
        exp_v("idle_ok_ignored", 0);
        step(1);
        check(estado);
        b_ok = 1'b0;

        // action coinciding with a tick on attr[0]=0xF8
        tick_step(0);
        tick_step(0);
        exp_v("pre_net_attr0", 8'hF8);
        check(attr[7:0]);
        step(1);
        b_sel = 1'b1;
        exp_v("net_menu", 1);
        step(1);
        check(estado);
        b_sel = 1'b0;
        b_ok  = 1'b1;
        exp_v("net_acao", 2);
        exp_v("net_acao_attr", pk());
        step(1);
        check(estado); check(attr);
        b_ok = 1'b0;
        decay();
        ea[0] = sat8(248 - 1 + 16);
        exp_v("net_anim", 3);
        exp_v("net_tick", 1);
        exp_v("net_attr", pk());
        exp_v("net_attr0_sat", 8'hFF);
        exp_v("net_attr2_dec", 8'hF7);
        step(1);
        check(estado); check(tick); check(attr); check(attr[7:0]); check(attr[23:16]);
        tick_step(3);
        tick_step(0);

        // decay until attr[1]=0x11, then act on attr[1] across a tick
        while (ea[1] != 'h11) tick_step(0);
        step(1);
        b_sel = 1'b1;
        exp_v("act_menu", 1);
        exp_v("act_sel0", 0);
        step(1);
        check(estado); check(sel);
        exp_v("act_sel1", 1);
        step(1);
        check(sel);
        b_ok = 1'b1;
        decay();
        exp_v("act_acao_ok_wins", 2);
        exp_v("act_sel_kept", 1);
        exp_v("act_acao_attr", pk());
        step(1);
        check(estado); check(sel); check(attr);
        b_sel = 1'b0;
        b_ok  = 1'b0;
        ea[1] = sat8(ea[1] + 16);
        exp_v("act_anim", 3);
        exp_v("act_attr1", 8'h20);
        exp_v("act_attr", pk());
        step(1);
        check(estado); check(attr[15:8]); check(attr);
        b_sel = 1'b1;
        exp_v("anim_btn_ignored", 3);
        exp_v("anim_sel_hold", 1);
        step(1);
        check(estado); check(sel);
        b_sel = 1'b0;
        tick_step(3);
        tick_step(0);
        exp_v("idle_sel_hold", 1);
        check(sel);

        // reset asserted mid-cycle during ANIM
        b_sel = 1'b1;
        step(1);
        b_sel = 1'b0;
        b_ok  = 1'b1;
        step(1);
        b_ok = 1'b0;
        step(1);
        exp_v("pre_rst_anim", 3);
        exp_v("pre_rst_tick", 1);
        step(1);
        check(estado); check(tick);
        #2;
        rst = 1'b1;
        set_full();
        exp_v("async_rst_attr", 24'hFFFFFF);
        exp_v("async_rst_estado", 0);
        exp_v("async_rst_sel", 0);
        exp_v("async_rst_morreu", 0);
        exp_v("async_rst_tick", 0);
        #1;
        check(attr); check(estado); check(sel); check(morreu); check(tick);
`ifdef NUCLEO_BICHINHO_IDADE_EN
        exp_v("rst_idade", 0);
        check(idade);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // starve the pet to death
        tick_step(0);
`ifdef NUCLEO_BICHINHO_IDADE_EN
        exp_v("idade_first", 1);
        check(idade);
`endif
        for (int k = 1; k < 255; k++) tick_step(0);
        exp_v("dead_attr_zero", 24'h000000);
        check(attr);
        exp_v("morto", 4);
        exp_v("morreu_set", 1);
        step(1);
        check(estado); check(morreu);
        tick_step(4);
        exp_v("morto_frozen_morreu", 1);
        check(morreu);
`ifdef NUCLEO_BICHINHO_IDADE_EN
        exp_v("idade_frozen", 255);
        check(idade);
`endif
        b_sel = 1'b1;
        exp_v("morto_sel_estado", 4);
        exp_v("morto_sel_attr", 24'h000000);
        step(1);
        check(estado); check(attr);
        b_sel = 1'b0;
        b_ok  = 1'b1;
        exp_v("morto_ok_estado", 4);
        exp_v("morto_ok_attr", 24'h000000);
        step(1);
        check(estado); check(attr);
        b_sel = 1'b1;
        set_full();
        exp_v("restart_attr", 24'hFFFFFF);
        exp_v("restart_estado", 0);
        exp_v("restart_morreu", 0);
        exp_v("restart_sel", 0);
        exp_v("restart_tick", 0);
        step(1);
        check(attr); check(estado); check(morreu); check(sel); check(tick);
        b_sel = 1'b0;
        b_ok  = 1'b0;
        exp_v("restart_pre_tick", 0);
        step(3);
        check(tick);
        decay();
        exp_v("restart_first_tick", 1);
        exp_v("restart_first_attr", 24'hFEFEFE);
        step(1);
        check(tick); check(attr);
`ifdef NUCLEO_BICHINHO_IDADE_EN
        exp_v("restart_idade", 1);
        check(idade);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nucleo_bichinho.md
NUCLEO_BICHINHO -- requirements
Module: nucleo_bichinho

Interface
REQ-001 SHALL have parameter N_ATTR, default 3: number of pet attributes (channels), range 1..8.
REQ-002 SHALL have parameter ATTR_W, default 8: width of each attribute value.
REQ-003 SHALL have parameter TICK_DIV, default 12000000: clk cycles per decay tick, minimum 2.
REQ-004 SHALL have parameters DEC_STEP (default 1), ACT_STEP (default 16), MENU_TO (default 5) and ANIM_TICKS (default 2).
- DEC_STEP: decay per tick.
- ACT_STEP: gain per action.
- MENU_TO: menu timeout in ticks.
- ANIM_TICKS: animation hold in ticks.
REQ-005 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  reset.
REQ-006 Reset SHALL be asynchronous and active-high, on the single clock clk.
REQ-007 SHALL have further ports:
- b_sel  in  1  debounced one-cycle select pulse.
- b_ok  in  1  debounced one-cycle confirm pulse.
- estado  out  4  FSM state.
- sel  out  3  selected attribute index.
- attr  out  N_ATTR*ATTR_W  packed attributes, attribute i at bits [i*ATTR_W +: ATTR_W].
- tick  out  1  one-cycle decay tick.
- morreu  out  1  death flag.

Function
REQ-008 Prescaler SHALL count 0..TICK_DIV-1 and pulse tick for exactly the cycle on which it wraps; period is exactly TICK_DIV cycles.
REQ-009 On tick, outside MORTO, each attribute SHALL decrease by DEC_STEP, saturating at 0.
REQ-010 FSM SHALL use these estado encodings: IDLE=0, MENU=1, ACAO=2, ANIM=3, MORTO=4; no other value SHALL appear.
REQ-011 IDLE: b_sel SHALL enter MENU with sel=0; b_ok SHALL be ignored.
REQ-012 MENU transitions:
- b_sel advances sel, wrapping N_ATTR-1 to 0.
- b_ok enters ACAO.
- b_sel and b_ok in the same cycle: b_ok wins and sel is unchanged.
REQ-013 MENU SHALL return to IDLE after MENU_TO consecutive ticks with no b_sel/b_ok; any button pulse restarts the timeout count.
REQ-014 ACAO SHALL last exactly one cycle: attr[sel] increases by ACT_STEP, saturating at 2^ATTR_W-1, then the FSM enters ANIM.
REQ-015 If a tick coincides with ACAO, attr[sel] SHALL become the saturated net value (v - DEC_STEP + ACT_STEP) clamped to [0, 2^ATTR_W-1], computed at ATTR_W+2 bits; other attributes decay normally.
REQ-016 ANIM SHALL hold for ANIM_TICKS ticks, then return to IDLE; buttons SHALL be ignored during ANIM.
REQ-017 Death entry SHALL occur from any state when any attribute equals 0 at the end of a tick update: the FSM enters MORTO on the next cycle and morreu=1.
REQ-018 Death SHALL take priority over all other transitions.
REQ-019 MORTO behaviour:
- Decay is frozen.
- Single button pulses are ignored.
- b_sel and b_ok in the same cycle restart the pet: all attributes set to max, sel=0, morreu=0, FSM to IDLE, prescaler cleared.
REQ-020 sel SHALL hold its value outside MENU.
REQ-021 attr, estado, sel and morreu SHALL all be registered outputs.

Reset
REQ-022 On rst=1, regardless of clk, the block SHALL set:
- attributes = 2^ATTR_W-1.
- estado = IDLE (0), sel = 0, tick = 0, morreu = 0.
- prescaler, menu timeout and animation counters = 0.
REQ-023 Reset asserted mid-ACAO/ANIM/MORTO SHALL discard any in-progress action, with no partial update visible after release.
REQ-024 The first tick after reset release SHALL occur exactly TICK_DIV cycles after release.

Configuration
REQ-025 With macro NUCLEO_BICHINHO_IDADE_EN defined, the block SHALL add output idade (16 bits): it counts ticks since reset/restart, saturates at 0xFFFF, freezes in MORTO and clears on reset or restart.
REQ-026 Without NUCLEO_BICHINHO_IDADE_EN, port idade and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (TICK_DIV=4, N_ATTR=3, ATTR_W=8, DEC_STEP=1, ACT_STEP=16, MENU_TO=3, ANIM_TICKS=2)
REQ-027 Pulse rst, release -> attr=0xFFFFFF, estado=0, morreu=0; tick on cycle 4 after release -> every attribute 0xFE.
REQ-028 With attr[1]=0x10: b_sel, b_sel, b_ok -> sel=1, estado 1->2->3, attr[1]=0x20; after 2 ticks -> estado=0.
REQ-029 In MENU, b_sel x3 -> sel 1,2,0; then no input for 3 ticks -> estado=0, sel stays 0.
REQ-030 Feed attr[0]=0xF8 with ACAO coinciding with a tick -> attr[0]=0xFF (saturated net); attr[2] decremented by 1.
REQ-031 Run 255 ticks idle from reset -> all attributes 0, estado=4, morreu=1, values frozen on later ticks; b_sel alone -> no change; b_sel+b_ok same cycle -> attrs 0xFF, estado=0, morreu=0.
REQ-032 Assert rst during ANIM mid-tick -> immediate reset values; with NUCLEO_BICHINHO_IDADE_EN, idade=0 and increments to 1 at the first tick.
